// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types and constants for the two-digit display multiplexer
package display_pkg;

    typedef enum logic [1:0] {
        SHOW0  = 2'd0,
        BLANK0 = 2'd1,
        SHOW1  = 2'd2,
        BLANK1 = 2'd3
    } state_t;

    localparam int REFRESH_CYCLES_DEFAULT = 24000;
    localparam int BLANK_CYCLES_DEFAULT   = 240;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

endpackage

// File: rtl/display_controller.sv
// rtl/display_controller.sv - hex nibble to active-low seven-segment decoder
module display_controller (
    input  logic [3:0] s,
    output logic [6:0] seg
);

    // Segment order is {g,f,e,d,c,b,a}; a zero lights the segment.
    always_comb begin
        seg = 7'b1111111;
        case (s)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'ha: seg = 7'b0001000;
            4'hb: seg = 7'b0000011;
            4'hc: seg = 7'b1000110;
            4'hd: seg = 7'b0100001;
            4'he: seg = 7'b0000110;
            4'hf: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/display_mux.sv
// rtl/display_mux.sv - time-multiplexed two-digit seven-segment driver with blanking gaps
module display_mux
    import display_pkg::*;
#(
    parameter int REFRESH_CYCLES = REFRESH_CYCLES_DEFAULT,
    parameter int BLANK_CYCLES   = BLANK_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] s0,
    input  logic [3:0] s1,
    output logic [6:0] seg,
    output logic [1:0] an
);

    // Counter sized for the longer slot so it never wraps inside one.
    localparam int MAX_CYCLES = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES);

    localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [3:0]    cur;
    logic [3:0]    cur_next;
    logic [6:0]    dec_seg;
    logic          slot_last;

    // The single shared decoder only ever sees the latched digit value.
    display_controller u_dec (
        .s   (cur),
        .seg (dec_seg)
    );

    // State, slot counter and latched digit; reset parks in the dark slot before digit 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BLANK1;
            cnt   <= '0;
            cur   <= 4'h0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            cur   <= cur_next;
        end
    end

    // Next-state: disable overrides terminal count; digits are sampled only when entering a SHOW slot.
    always_comb begin
        state_next = state;
        cnt_next   = cnt + 1'b1;
        cur_next   = cur;
        slot_last  = ((state == SHOW0) || (state == SHOW1)) ? (cnt == SHOW_LAST)
                                                             : (cnt == BLANK_LAST);
        if (!en) begin
            state_next = BLANK1;
            cnt_next   = '0;
        end else if (slot_last) begin
            cnt_next = '0;
            case (state)
                SHOW0:  state_next = BLANK0;
                BLANK0: begin
                    state_next = SHOW1;
                    cur_next   = s1;
                end
                SHOW1:  state_next = BLANK1;
                BLANK1: begin
                    state_next = SHOW0;
                    cur_next   = s0;
                end
                default: state_next = BLANK1;
            endcase
        end
    end

    // Outputs come purely from registered state, so no input can glitch the display mid-slot.
    always_comb begin
        an  = 2'b11;
        seg = SEG_OFF;
        case (state)
            SHOW0: begin
                an  = 2'b10;
                seg = dec_seg;
            end
            SHOW1: begin
                an  = 2'b01;
                seg = dec_seg;
            end
            default: begin
                an  = 2'b11;
                seg = SEG_OFF;
            end
        endcase
    end

endmodule

// File: tb/tb_display_mux.sv
// tb/tb_display_mux.sv - directed table-driven bench for display_mux
module tb_display_mux;

    localparam logic [6:0] OFF = 7'b1111111;
    localparam logic [6:0] D0  = 7'b1000000;
    localparam logic [6:0] D1  = 7'b1111001;
    localparam logic [6:0] D3  = 7'b0110000;
    localparam logic [6:0] D8  = 7'b0000000;

    typedef struct {
        logic       en;
        logic [3:0] s0;
        logic [3:0] s1;
        logic [1:0] an;
        logic [6:0] seg;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] s0;
    logic [3:0] s1;
    logic [6:0] seg;
    logic [1:0] an;

    int checks   = 0;
    int failures = 0;

    vec_t vecs[$];

    display_mux #(
        .REFRESH_CYCLES (8),
        .BLANK_CYCLES   (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .s0    (s0),
        .s1    (s1),
        .seg   (seg),
        .an    (an)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [1:0] an_exp, input logic [6:0] seg_exp);
        checks++;
        if (an !== an_exp || seg !== seg_exp) begin
            failures++;
            $display("FAIL %s: an=%b seg=%b, required an=%b seg=%b", name, an, seg, an_exp, seg_exp);
        end
    endtask

    task automatic add(input int n, input logic e, input logic [3:0] a, input logic [3:0] b,
                       input logic [1:0] an_e, input logic [6:0] seg_e);
        vec_t v;
        v.en = e; v.s0 = a; v.s1 = b; v.an = an_e; v.seg = seg_e;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    // Invariants on every cycle: never both digits on, and dark digits show no segments.
    always @(negedge clk) begin
        checks++;
        if (an === 2'b00 || (an === 2'b11 && seg !== OFF)) begin
            failures++;
            $display("FAIL invariant @%0t: an=%b seg=%b, required an!=00 and seg=%b when an=11",
                     $time, an, seg, OFF);
        end
    end

    initial begin
        int i;
        bit found;

        // Cycle-by-cycle schedule starting right after reset release (s1 stays 8 throughout).
        add(2, 1'b1, 4'h3, 4'h8, 2'b11, OFF);   // V1 lead-in blank
        add(8, 1'b1, 4'h1, 4'h8, 2'b10, D3);    // digit 0 keeps 3 though s0 moved to 1
        add(2, 1'b1, 4'h1, 4'h8, 2'b11, OFF);
        add(8, 1'b1, 4'h1, 4'h8, 2'b01, D8);
        add(2, 1'b1, 4'h1, 4'h8, 2'b11, OFF);
        add(8, 1'b1, 4'h1, 4'h8, 2'b10, D1);    // V2 20-cycle period
        add(2, 1'b1, 4'h1, 4'h8, 2'b11, OFF);
        add(8, 1'b1, 4'h1, 4'h8, 2'b01, D8);
        add(2, 1'b1, 4'h1, 4'h8, 2'b11, OFF);
        add(3, 1'b1, 4'h1, 4'h8, 2'b10, D1);    // V3: s0 changes at slot cycle 3
        add(5, 1'b1, 4'h0, 4'h8, 2'b10, D1);
        add(2, 1'b1, 4'h0, 4'h8, 2'b11, OFF);
        add(8, 1'b1, 4'h0, 4'h8, 2'b01, D8);
        add(2, 1'b1, 4'h0, 4'h8, 2'b11, OFF);
        add(8, 1'b1, 4'h0, 4'h8, 2'b10, D0);    // new s0 appears at next SHOW0
        add(2, 1'b1, 4'h0, 4'h8, 2'b11, OFF);
        add(4, 1'b1, 4'h0, 4'h8, 2'b01, D8);    // V4: en drops at SHOW1 cycle 4
        add(1, 1'b0, 4'h0, 4'h8, 2'b01, D8);
        add(4, 1'b0, 4'h0, 4'h8, 2'b11, OFF);
        add(2, 1'b1, 4'h0, 4'h8, 2'b11, OFF);   // en back: two blank cycles
        add(8, 1'b1, 4'h0, 4'h8, 2'b10, D0);
        add(2, 1'b1, 4'h0, 4'h8, 2'b11, OFF);
        add(8, 1'b1, 4'h0, 4'h8, 2'b01, D8);

        reset = 1'b1;
        en    = 1'b1;
        s0    = 4'h3;
        s1    = 4'h8;
        tick();
        tick();
        tick();
        check("reset_hold", 2'b11, OFF);
        reset = 1'b0;

        for (i = 0; i < vecs.size(); i++) begin
            en = vecs[i].en;
            s0 = vecs[i].s0;
            s1 = vecs[i].s1;
            check($sformatf("vec%0d", i), vecs[i].an, vecs[i].seg);
            tick();
        end

        // V5: asynchronous reset in the middle of a SHOW0 slot.
        en = 1'b1;
        s0 = 4'h3;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (an === 2'b10) found = 1'b1;
            else tick();
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL v5_reach_show0: an=%b, required an=10 within 40 cycles", an);
        end
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("v5_async_dark", 2'b11, OFF);
        tick();
        check("v5_reset_held", 2'b11, OFF);
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("v5_blank%0d", k), 2'b11, OFF);
            tick();
        end
        for (int k = 0; k < 8; k++) begin
            check($sformatf("v5_show0_%0d", k), 2'b10, D3);
            tick();
        end
        check("v5_blank0", 2'b11, OFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
